// File: rtl/bus_seq.sv
// Memory bus sequencer: arbitrates fetch/data/stack requests onto the shared 8-bit data / 16-bit address bus.
// Define BUS_SEQ_RR_EN for round-robin arbitration; otherwise fixed priority stack > data > fetch.
module bus_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [2:0]  req_we,
   input  logic [2:0]  req_wide,
   input  logic [47:0] req_addr,
   input  logic [47:0] req_wdata,
   output logic [2:0]  done,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [15:0] addrbus,
   output logic        rw,
   output logic [7:0]  dataout,
   input  logic [7:0]  datain
);

   typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;

   state_t      r_state;
   state_t      w_nextState;

   logic        r_we;
   logic        r_wide;
   logic        r_idx;
   logic [1:0]  r_slot;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;

   logic [2:0]  r_done;
   logic [15:0] r_rdata;
   logic        r_busy;
   logic [15:0] r_addrbus;
   logic        r_rw;
   logic [7:0]  r_dataout;

   logic [2:0]  w_done;
   logic [15:0] w_rdata;
   logic        w_busy;
   logic [15:0] w_addrbus;
   logic        w_rw;
   logic [7:0]  w_dataout;

   logic        w_any;
   logic [1:0]  w_winner;
   logic        w_selWe;
   logic        w_selWide;
   logic [15:0] w_selAddr;
   logic [15:0] w_selWdata;

   assign w_any = |req;

`ifdef BUS_SEQ_RR_EN
   // Returns the first requesting slot in the search order a, b, c.
   function automatic logic [1:0] pick3(input logic [2:0] r, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
      if (r[a])
         return a;
      else if (r[b])
         return b;
      else
         return c;
   endfunction

   logic [1:0] r_ptr;

   always_comb begin
      w_winner = 2'd0;
      case (r_ptr)
         2'd0:    w_winner = pick3(req, 2'd1, 2'd2, 2'd0);
         2'd1:    w_winner = pick3(req, 2'd2, 2'd0, 2'd1);
         default: w_winner = pick3(req, 2'd0, 2'd1, 2'd2);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_ptr <= 2'd0;
      else if (r_state == IDLE && w_any)
         r_ptr <= w_winner;
   end
`else
   always_comb begin
      w_winner = 2'd0;
      if (req[2])
         w_winner = 2'd2;
      else if (req[1])
         w_winner = 2'd1;
   end
`endif

   always_comb begin
      w_selWe    = req_we[w_winner];
      w_selWide  = req_wide[w_winner];
      w_selAddr  = req_addr[{w_winner, 4'b0000} +: 16];
      w_selWdata = req_wdata[{w_winner, 4'b0000} +: 16];
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_any) w_nextState = ADDR;
         ADDR:    w_nextState = XFER;
         XFER:    w_nextState = (r_wide && !r_idx) ? ADDR : DONE;
         default: w_nextState = IDLE;
      endcase
   end

   // Computes next values for the registered outputs so no pin is driven combinationally from req.
   always_comb begin
      w_addrbus = r_addrbus;
      w_rw      = r_rw;
      w_dataout = r_dataout;
      w_rdata   = r_rdata;
      w_done    = 3'b000;
      w_busy    = (w_nextState != IDLE);
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_addrbus = w_selAddr;
               w_rw      = w_selWe;
               w_dataout = w_selWdata[7:0];
               w_rdata   = 16'h0000;
            end
         end
         XFER: begin
            if (!r_we) begin
               if (r_idx)
                  w_rdata[15:8] = datain;
               else
                  w_rdata[7:0] = datain;
            end
            if (w_nextState == ADDR) begin
               w_addrbus = r_addr + 16'd1;
               w_dataout = r_wdata[15:8];
            end else begin
               w_rw   = 1'b0;
               w_done = 3'b001 << r_slot;
            end
         end
         DONE:    w_rw = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we      <= 1'b0;
         r_wide    <= 1'b0;
         r_idx     <= 1'b0;
         r_slot    <= 2'd0;
         r_addr    <= 16'h0000;
         r_wdata   <= 16'h0000;
         r_addrbus <= 16'h0000;
         r_rw      <= 1'b0;
         r_dataout <= 8'h00;
         r_rdata   <= 16'h0000;
         r_done    <= 3'b000;
         r_busy    <= 1'b0;
      end else begin
         if (r_state == IDLE && w_any) begin
            r_we    <= w_selWe;
            r_wide  <= w_selWide;
            r_idx   <= 1'b0;
            r_slot  <= w_winner;
            r_addr  <= w_selAddr;
            r_wdata <= w_selWdata;
         end else if (r_state == XFER && w_nextState == ADDR) begin
            r_idx <= 1'b1;
         end
         r_addrbus <= w_addrbus;
         r_rw      <= w_rw;
         r_dataout <= w_dataout;
         r_rdata   <= w_rdata;
         r_done    <= w_done;
         r_busy    <= w_busy;
      end
   end

   assign done    = r_done;
   assign rdata   = r_rdata;
   assign busy    = r_busy;
   assign addrbus = r_addrbus;
   assign rw      = r_rw;
   assign dataout = r_dataout;

endmodule

// File: doc/bus_seq.md
# bus_seq

Memory bus sequencer for the JAVK CPU. It owns the single 8-bit data bus and 16-bit address bus and shares them between three requesters: instruction fetch, data load/store and stack push/pop. Each transaction moves one or two bytes; two-byte transfers are little-endian. The block sits between `ctrl`/the register datapath and the external bus pins, and replaces direct driving of `addrbus`/`rw` by the core.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, synchronous, active-high.
- req  input  3  transaction request per slot; slot 0 = fetch, 1 = data, 2 = stack.
- req_we  input  3  per slot: 1 = write, 0 = read.
- req_wide  input  3  per slot: 1 = two bytes, 0 = one byte.
- req_addr  input  48  slot k base address at [16k+15:16k].
- req_wdata  input  48  slot k write data at [16k+15:16k]; low byte goes to base address.
- done  output  3  one-cycle completion pulse, one-hot, for the granted slot.
- rdata  output  16  read result; valid while `done` is high. Single-byte reads zero-extend.
- busy  output  1  high in every state except IDLE.
- addrbus  output  16  bus address.
- rw  output  1  1 = write cycle, 0 = read.
- dataout  output  8  write byte; valid when `rw` = 1.
- datain  input  8  read byte from the bus tristate.

## Operation
- FSM states: IDLE, ADDR, XFER, DONE.
- **IDLE**
  - If any `req` bit is high, select a winner and latch its `we`, `wide`, `addr` and `wdata`.
  - Set byte index = 0 and go to ADDR.
  - Requester inputs may change after the grant edge.
- **ADDR**
  - `addrbus` = base + byte index.
  - For writes: `rw` = 1 and `dataout` = selected write byte.
  - Next state is XFER.
- **XFER**
  - Same bus values as ADDR.
  - For reads, sample `datain` at the closing edge into `rdata[8*idx+7:8*idx]`.
  - If `wide` and idx = 0: set idx = 1 and go to ADDR.
  - Otherwise go to DONE.
- **DONE**
  - `done[granted]` = 1 for exactly one cycle.
  - `rw` = 0; `addrbus` holds its last value.
  - Next state is IDLE.
- Address arithmetic is 16-bit modulo: base 0xFFFF, wide → bytes at 0xFFFF then 0x0000.
- `rdata` is cleared to 0 at grant, so a narrow read returns {8'h00, byte}. On writes `rdata` holds 0.
- Fixed priority (default): stack > data > fetch.
- A requester that keeps `req` high through `done` is re-arbitrated in the following IDLE cycle as a new transaction.
- A requester that drops `req` before its grant simply loses its turn. Nothing is queued.

## Timing
- Assume `req` is high before edge N and the FSM is in IDLE.
  - Edge N: enter ADDR.
  - Edge N+1: enter XFER.
  - Edge N+2: enter DONE (narrow) or ADDR for byte 1 (wide).
- Narrow transaction: `done` high between edges N+2 and N+3.
- Wide transaction: `done` high between edges N+4 and N+5.
- Minimum spacing between back-to-back grants: narrow 4 cycles (IDLE, ADDR, XFER, DONE), wide 6 cycles.
- Reset values (also when `rst` arrives mid-transaction; it aborts with no `done`):
  - state = IDLE
  - `addrbus` = 0, `rw` = 0, `dataout` = 0
  - `rdata` = 0, `done` = 0, `busy` = 0
  - round-robin pointer = slot 0
- `rw` is never 1 outside ADDR/XFER of a write.
- All outputs are registered; no combinational path from `req` to bus pins.

## Configuration
- Macro `BUS_SEQ_RR_EN`.
- Defined: round-robin arbitration.
  - The pointer records the last granted slot.
  - The search order starts at pointer+1 mod 3.
  - The pointer updates at each grant.
- Undefined: fixed priority stack > data > fetch; no pointer register.

## Test plan
- Narrow fetch read: `req`=001, `req_addr[15:0]`=0x1234, bus returns 0xA5 → `addrbus`=0x1234 for 2 cycles, `rw`=0, `rdata`=0x00A5, `done`=001 at N+2.
- Wide stack write with wrap: slot 2, addr 0xFFFF, wdata 0xBEEF → `rw`=1 with `dataout`=0xEF at 0xFFFF, then 0xBE at 0x0000, `done`=100 at N+4.
- Fixed-priority collision (macro off): `req`=111 held → grant order 2,2,2…; fetch is starved, `done` is always 100.
- Round-robin collision (macro on): `req`=111 held from reset → grant order 1,2,0,1,2,0, each `done` 4 cycles apart.
- Wide data read 0x8000 returning 0x11, 0x22 → `rdata`=0x2211, `busy` high for 5 cycles.
- Reset during XFER of a write → next cycle `rw`=0, `addrbus`=0, `busy`=0, no `done`, and the FSM regrants cleanly if `req` is still high.
